// File: rtl/pattern_render.sv
// Test-pattern renderer: colour bars, grid, gray ramp or an auto-cycle of all three.
// Pixels are registered and aligned to DSP_DE, which lags DSP_preDE by one cycle.
module pattern_render (
    input  logic       DCLK,
    input  logic       DRST,
    input  logic [1:0] RESOL,
    input  logic [1:0] PAT_SEL,
    input  logic       DSP_preDE,
    input  logic       DSP_VSYNC_X,
    output logic       DSP_DE,
    output logic [7:0] DSP_R,
    output logic [7:0] DSP_G,
    output logic [7:0] DSP_B
);
    // Pattern/state codes share the PAT_SEL encoding, so mode selection is a plain mux.
    localparam logic [1:0] ST_BARS = 2'd0;
    localparam logic [1:0] ST_GRID = 2'd1;
    localparam logic [1:0] ST_RAMP = 2'd2;
    localparam logic [1:0] PAT_AUTO = 2'd3;

    logic        pre_de_d, vs_d;
    logic [10:0] x, y;
    logic [7:0]  sub;
    logic [2:0]  idx;
    logic [1:0]  res_l, pat_l;
    logic [1:0]  fsm, fsm_next;
    logic [5:0]  frame_cnt;

    logic        vs_fall, de_fall;
    logic [7:0]  bar_w_m1;
    logic [1:0]  mode;
    logic [23:0] pix;
    logic        unused_bits;

    assign vs_fall     = vs_d & ~DSP_VSYNC_X;
    assign de_fall     = pre_de_d & ~DSP_preDE;
    assign mode        = (pat_l == PAT_AUTO) ? fsm : pat_l;
    assign unused_bits = ^{y[10:5], x[10]};

    always_comb begin
        bar_w_m1 = 8'd79;
        case (res_l)
            2'b00:   bar_w_m1 = 8'd79;
            2'b01:   bar_w_m1 = 8'd99;
            2'b10:   bar_w_m1 = 8'd127;
            default: bar_w_m1 = 8'd159;
        endcase
    end

    always_comb begin
        fsm_next = ST_BARS;
        case (fsm)
            ST_BARS: fsm_next = ST_GRID;
            ST_GRID: fsm_next = ST_RAMP;
            default: fsm_next = ST_BARS;
        endcase
    end

    // Bar channels: R on for indices with bit1 clear, G for bit2 clear, B for bit0 clear.
    always_comb begin
        pix = 24'h000000;
        case (mode)
            ST_BARS: pix = {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
            ST_GRID: pix = (x[4:0] == 5'd0 || y[4:0] == 5'd0) ? 24'hFFFFFF : 24'h000000;
            ST_RAMP: pix = {3{x[9:2]}};
            default: pix = 24'h000000;
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            pre_de_d  <= 1'b0;
            vs_d      <= 1'b0;
            x         <= '0;
            y         <= '0;
            sub       <= '0;
            idx       <= '0;
            res_l     <= 2'b00;
            pat_l     <= 2'b00;
            fsm       <= ST_BARS;
            frame_cnt <= '0;
            DSP_DE    <= 1'b0;
            DSP_R     <= '0;
            DSP_G     <= '0;
            DSP_B     <= '0;
        end else begin
            pre_de_d <= DSP_preDE;
            vs_d     <= DSP_VSYNC_X;

            if (DSP_preDE) begin
                x <= x + 11'd1;
                if (sub == bar_w_m1) begin
                    sub <= '0;
                    if (idx != 3'd7) idx <= idx + 3'd1;
                end else begin
                    sub <= sub + 8'd1;
                end
            end else begin
                x   <= '0;
                sub <= '0;
                idx <= '0;
            end

            if (vs_fall)      y <= '0;
            else if (de_fall) y <= y + 11'd1;

            // Settings only move at frame start; entering auto mode restarts the cycle.
            if (vs_fall) begin
                res_l <= RESOL;
                pat_l <= PAT_SEL;
                if (PAT_SEL == PAT_AUTO) begin
                    if (pat_l != PAT_AUTO) begin
                        fsm       <= ST_BARS;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 6'd1;
                        if (frame_cnt == 6'd63) fsm <= fsm_next;
                    end
                end
            end

            DSP_DE <= DSP_preDE;
            {DSP_R, DSP_G, DSP_B} <= DSP_preDE ? pix : 24'h000000;
        end
    end
endmodule
